// File: rtl/axi_sram_slave_pkg.sv
// Shared types for the AXI3 SRAM responder: response/burst codes, FSM states
// and the address-phase error classifier.
package axi_sram_slave_pkg;

  localparam int unsigned IdWDefault = 4;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_e;

  typedef enum logic {
    StRIdle,
    StRData
  } rd_state_e;

  typedef enum logic [1:0] {
    StWIdle,
    StWData,
    StWResp
  } wr_state_e;

  // DECERR wins over SLVERR; only FIXED/INCR bursts of full words are served.
  function automatic resp_e calc_err(input logic [31:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst,
                                     input int unsigned addr_w);
    if ((addr >> (addr_w + 2)) != 32'd0) return RespDecerr;
    if (!(burst == BurstFixed || burst == BurstIncr) || size > 3'b010 ||
        (len != 8'd0 && size < 3'b010)) return RespSlverr;
    return RespOkay;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between a master and the SRAM responder.
interface axi_sram_slave_if #(
  parameter int unsigned ID_W = axi_sram_slave_pkg::IdWDefault
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_sram_slave_mem.sv
// Word-addressed 32-bit memory: registered read port, byte-strobed write port,
// same-address write-first bypass into the read register.
module axi_sram_slave_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] merged;

  always_comb begin
    merged = mem[rd_addr];
    if (wr_en && wr_addr == rd_addr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Array has no reset so contents survive areset.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_data <= 32'd0;
    end else if (rd_en) begin
      rd_data <= merged;
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder over an on-chip memory; independent read and write burst FSMs,
// one burst in flight per direction.
module axi_sram_slave import axi_sram_slave_pkg::*; #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ID_W   = IdWDefault
) (
  input  logic        aclk,
  input  logic        areset,
  axi_sram_slave_if.slave bus
);

  // Read channel state
  rd_state_e         rd_state_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [ID_W-1:0]   rid_q;
  resp_e             rresp_q;
  logic [ADDR_W-1:0] ridx_q, ridx_next, ar_idx;
  logic [7:0]        rlen_q, rcnt_q;
  logic [1:0]        rburst_q;
  logic              ar_hs, r_hs, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       mem_rdata;
  resp_e             ar_err;

  // Write channel state
  wr_state_e         wr_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [ID_W-1:0]   awid_q, bid_q;
  resp_e             werr_q, bresp_q, aw_err, beat_err;
  logic [ADDR_W-1:0] widx_q, widx_next;
  logic [7:0]        wlen_q, wcnt_q;
  logic [1:0]        wburst_q;
  logic              aw_hs, w_hs, b_hs, w_end, beat_bad, wr_en;

  logic unused_bus;
  assign unused_bus = ^{bus.arlock, bus.arcache, bus.arprot, bus.awlock, bus.awcache,
                        bus.awprot, bus.araddr[1:0], bus.awaddr[1:0]};

  assign ar_hs     = bus.arvalid && arready_q;
  assign r_hs      = rvalid_q && bus.rready;
  assign ar_idx    = bus.araddr[ADDR_W+1:2];
  assign ar_err    = calc_err(bus.araddr, bus.arlen, bus.arsize, bus.arburst, ADDR_W);
  assign ridx_next = (rburst_q == BurstFixed) ? ridx_q : ridx_q + 1'b1;
  // Prefetch the next beat as the current one is accepted.
  assign rd_en     = ar_hs || (r_hs && !rlast_q);
  assign rd_addr   = ar_hs ? ar_idx : ridx_next;

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q <= StRIdle;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= RespOkay;
      ridx_q     <= '0;
      rlen_q     <= 8'd0;
      rcnt_q     <= 8'd0;
      rburst_q   <= 2'b00;
    end else begin
      unique case (rd_state_q)
        StRIdle: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rid_q      <= bus.arid;
            ridx_q     <= ar_idx;
            rlen_q     <= bus.arlen;
            rcnt_q     <= 8'd0;
            rburst_q   <= bus.arburst;
            rresp_q    <= ar_err;
            rlast_q    <= (bus.arlen == 8'd0);
            rd_state_q <= StRData;
          end
        end
        StRData: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
              rd_state_q <= StRIdle;
            end else begin
              rcnt_q  <= rcnt_q + 8'd1;
              ridx_q  <= ridx_next;
              rlast_q <= (rcnt_q + 8'd1 == rlen_q);
            end
          end
        end
      endcase
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = (rresp_q == RespOkay) ? mem_rdata : 32'd0;

  assign aw_hs     = bus.awvalid && awready_q;
  assign w_hs      = bus.wvalid && wready_q;
  assign b_hs      = bvalid_q && bus.bready;
  assign aw_err    = calc_err(bus.awaddr, bus.awlen, bus.awsize, bus.awburst, ADDR_W);
  assign widx_next = (wburst_q == BurstFixed) ? widx_q : widx_q + 1'b1;
  assign w_end     = bus.wlast || (wcnt_q == wlen_q);
  assign beat_bad  = (bus.wid != awid_q) || (bus.wlast != (wcnt_q == wlen_q));
  // A protocol slip on a beat only downgrades an OKAY burst; DECERR stays.
  assign beat_err  = (werr_q == RespOkay && beat_bad) ? RespSlverr : werr_q;
  assign wr_en     = w_hs && (werr_q == RespOkay) && (bus.wid == awid_q);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= StWIdle;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RespOkay;
      awid_q     <= '0;
      werr_q     <= RespOkay;
      widx_q     <= '0;
      wlen_q     <= 8'd0;
      wcnt_q     <= 8'd0;
      wburst_q   <= 2'b00;
    end else begin
      unique case (wr_state_q)
        StWIdle: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            awid_q     <= bus.awid;
            widx_q     <= bus.awaddr[ADDR_W+1:2];
            wlen_q     <= bus.awlen;
            wcnt_q     <= 8'd0;
            wburst_q   <= bus.awburst;
            werr_q     <= aw_err;
            wr_state_q <= StWData;
          end
        end
        StWData: begin
          if (w_hs) begin
            widx_q <= widx_next;
            wcnt_q <= wcnt_q + 8'd1;
            werr_q <= beat_err;
            if (w_end) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bresp_q    <= beat_err;
              bid_q      <= awid_q;
              wr_state_q <= StWResp;
            end
          end
        end
        StWResp: begin
          if (b_hs) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= StWIdle;
          end
        end
        default: wr_state_q <= StWIdle;
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;

  axi_sram_slave_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .aclk    (aclk),
    .areset  (areset),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (mem_rdata),
    .wr_en   (wr_en),
    .wr_addr (widx_q),
    .wr_data (bus.wdata),
    .wr_strb (bus.wstrb)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: reset values, bursts, strobes, errors,
// rready back-pressure, write-first bypass and mid-burst reset.
module tb_axi_sram_slave;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  localparam int Lim = 20;

  logic [31:0] rd_data [8];
  logic [1:0]  rd_resp [8];
  logic        rd_last [8];
  logic [3:0]  rd_id   [8];
  int          rd_n, r_cycles;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;

  always #5 aclk = ~aclk;

  axi_sram_slave_if #(.ID_W(4)) bus ();

  axi_sram_slave #(
    .ADDR_W(10),
    .ID_W  (4)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=handshake within %0d cycles", tag, Lim);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] d0,
                          input logic [3:0] strb);
    int n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'b010;
    bus.awburst = burst; bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < Lim) begin tick(); n++; end
    if (n >= Lim) timeout("aw_wait");
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wid = id; bus.wdata = d0 + 32'(i); bus.wstrb = strb;
      bus.wlast = (i == int'(len)); bus.wvalid = 1'b1;
      n = 0;
      while (bus.wready !== 1'b1 && n < Lim) begin tick(); n++; end
      if (n >= Lim) timeout("w_wait");
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < Lim) begin tick(); n++; end
    if (n >= Lim) timeout("b_wait");
    b_id = bus.bid; b_resp = bus.bresp;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle);
    int n, cyc;
    bit held;
    logic [31:0] h_data;
    logic h_last;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'b010;
    bus.arburst = burst; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < Lim) begin tick(); n++; end
    if (n >= Lim) timeout("ar_wait");
    tick();
    bus.arvalid = 1'b0;
    check("rvalid_latency", bus.rvalid, 1);
    rd_n = 0; cyc = 0; held = 0; h_data = 0; h_last = 0;
    while (rd_n <= int'(len) && cyc < 64) begin
      bus.rready = toggle ? ~cyc[0] : 1'b1;
      if (held) begin
        check("r_hold_data", bus.rdata, h_data);
        check("r_hold_last", bus.rlast, h_last);
      end
      held = 0;
      if (bus.rvalid === 1'b1 && bus.rready) begin
        if (rd_n < 8) begin
          rd_data[rd_n] = bus.rdata; rd_resp[rd_n] = bus.rresp;
          rd_last[rd_n] = bus.rlast; rd_id[rd_n] = bus.rid;
        end
        rd_n++;
      end else if (bus.rvalid === 1'b1) begin
        held = 1; h_data = bus.rdata; h_last = bus.rlast;
      end
      tick();
      cyc++;
    end
    bus.rready = 1'b0;
    if (rd_n <= int'(len)) timeout("r_beats");
    r_cycles = cyc;
    check("r_no_extra_beat", bus.rvalid, 0);
    check("arready_after_burst", bus.arready, 1);
  endtask

  initial begin
    bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 3'b010; bus.arburst = 2'b01;
    bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 3'b010; bus.awburst = 2'b01;
    bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awvalid = 0;
    bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;

    // Reset values
    tick(); tick(); tick();
    check("rst_arready", bus.arready, 0);
    check("rst_awready", bus.awready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_rid", bus.rid, 0);
    check("rst_bid", bus.bid, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rdata", bus.rdata, 0);
    areset = 1'b0;
    tick();
    check("idle_arready", bus.arready, 1);
    check("idle_awready", bus.awready, 1);
    check("idle_wready", bus.wready, 0);

    // Preload through the write channel
    do_write(4'd2, 32'h40, 8'd3, 2'b01, 32'hA0, 4'hF);
    check("pre_bresp", b_resp, 0);
    check("pre_bid", b_id, 2);
    do_write(4'd0, 32'h10, 8'd0, 2'b01, 32'hFFFF_FFFF, 4'hF);
    do_write(4'd0, 32'h20, 8'd0, 2'b01, 32'h5555_5555, 4'hF);

    // INCR read, len=3, rready held high
    do_read(4'd1, 32'h40, 8'd3, 2'b01, 1'b0);
    check("rd1_cycles", r_cycles, 4);
    for (int i = 0; i < 4; i++) begin
      check("rd1_data", rd_data[i], 32'hA0 + 32'(i));
      check("rd1_last", rd_last[i], (i == 3) ? 1 : 0);
      check("rd1_id", rd_id[i], 1);
      check("rd1_resp", rd_resp[i], 0);
    end

    // Strobed single write
    do_write(4'd1, 32'h10, 8'd0, 2'b01, 32'h1122_3344, 4'b0101);
    check("strb_bresp", b_resp, 0);
    check("strb_bid", b_id, 1);
    do_read(4'd0, 32'h10, 8'd0, 2'b01, 1'b0);
    check("strb_word", rd_data[0], 32'hFF22_FF44);

    // rready toggling 1010..
    do_read(4'd5, 32'h40, 8'd3, 2'b01, 1'b1);
    check("tog_cycles", r_cycles, 7);
    for (int i = 0; i < 4; i++) begin
      check("tog_data", rd_data[i], 32'hA0 + 32'(i));
      check("tog_last", rd_last[i], (i == 3) ? 1 : 0);
    end

    // Out-of-range read -> DECERR with zero data
    do_read(4'd6, 32'h0001_0000, 8'd1, 2'b01, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("dec_resp", rd_resp[i], 2'b11);
      check("dec_data", rd_data[i], 0);
      check("dec_last", rd_last[i], (i == 1) ? 1 : 0);
    end

    // WRAP write -> SLVERR, memory untouched
    do_write(4'd7, 32'h40, 8'd0, 2'b10, 32'hDEAD_BEEF, 4'hF);
    check("wrap_bresp", b_resp, 2'b10);
    check("wrap_bid", b_id, 7);
    do_read(4'd0, 32'h40, 8'd0, 2'b01, 1'b0);
    check("wrap_mem", rd_data[0], 32'hA0);

    // Concurrent AR (FIXED len=1) and AW on word 0x20; second fetch meets the write
    bus.arid = 4'd8; bus.araddr = 32'h20; bus.arlen = 8'd1; bus.arburst = 2'b00;
    bus.awid = 4'd9; bus.awaddr = 32'h20; bus.awlen = 8'd0; bus.awburst = 2'b01;
    bus.arvalid = 1'b1; bus.awvalid = 1'b1;
    check("cc_arready", bus.arready, 1);
    check("cc_awready", bus.awready, 1);
    tick();
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    check("cc_beat0", bus.rdata, 32'h5555_5555);
    check("cc_wready", bus.wready, 1);
    bus.rready = 1'b1;
    bus.wid = 4'd9; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("cc_bypass", bus.rdata, 32'hCAFE_F00D);
    check("cc_rlast", bus.rlast, 1);
    check("cc_rid", bus.rid, 8);
    check("cc_bvalid", bus.bvalid, 1);
    check("cc_bresp", bus.bresp, 0);
    check("cc_bid", bus.bid, 9);
    bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    check("cc_rdone", bus.rvalid, 0);
    check("cc_bdone", bus.bvalid, 0);
    tick();
    check("cc_awready_back", bus.awready, 1);
    do_read(4'd0, 32'h20, 8'd0, 2'b01, 1'b0);
    check("cc_mem", rd_data[0], 32'hCAFE_F00D);

    // Reset during beat 2 of a len=3 read
    bus.arid = 4'd4; bus.araddr = 32'h40; bus.arlen = 8'd3; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    check("rr_beat1", bus.rdata, 32'hA0);
    tick();
    check("rr_beat2", bus.rdata, 32'hA1);
    areset = 1'b1; bus.rready = 1'b0;
    tick();
    check("rr_rvalid", bus.rvalid, 0);
    check("rr_arready", bus.arready, 0);
    areset = 1'b0;
    tick();
    check("rr_arready_back", bus.arready, 1);
    check("rr_rvalid_idle", bus.rvalid, 0);
    check("rr_no_b", bus.bvalid, 0);
    do_read(4'd0, 32'h4C, 8'd0, 2'b01, 1'b0);
    check("rr_mem", rd_data[0], 32'hA3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=no finish expected=finish before 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
